// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array feeder blocks.
package sys_array_pkg;

    // Feeder batch sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } skew_state_t;

    // Width needed to encode a lane count minus one.
    function automatic int unsigned len_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Turns a "length minus one" setting into an active lane count,
    // saturating at the physical number of lanes.
    function automatic int unsigned clamp_len(input int unsigned len_m1,
                                              input int unsigned max_l);
        return (len_m1 >= max_l) ? max_l : len_m1 + 1;
    endfunction

endpackage

// File: rtl/sys_array_delay_line.sv
// Data + valid shift register of DEPTH stages; DEPTH=0 is a plain wire.
module sys_array_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    if (DEPTH == 0) begin : g_pass
        // Clock and reset are not needed when there are no stages.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;
        assign out_data       = in_data;
        assign out_valid      = in_valid;
    end else begin : g_chain
        logic [DATA_WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0]      valid_q;

        // Shift data and its valid flag one stage per clock.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= in_data;
                valid_q[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        assign out_data  = data_q[DEPTH-1];
        assign out_valid = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/sys_array_input_skew.sv
// Feeder that turns unskewed matrix rows into the diagonal wavefront the
// systolic array consumes: lane k is delayed k cycles behind lane 0.
//
// Handshake: a row transfers on a rising edge where in_valid and in_ready are
// both high; in_row/in_last are ignored whenever in_valid is low. in_ready is
// high only in IDLE/STREAM and never during reset or the first cycle after it.
module sys_array_input_skew
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ARRAY_MAX_L = 10,
    parameter int LEN_W       = len_width(ARRAY_MAX_L)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [LEN_W-1:0]                        cfg_len_m1,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_last,
    input  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  in_row,
    output logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  out_data,
    output logic [0:ARRAY_MAX_L-1]                  out_lane_valid,
    output logic                                    busy,
    output logic                                    done
);

    skew_state_t state, state_nxt;
    logic [LEN_W:0]   len_q;       // active lane count of the current batch
    logic [LEN_W:0]   len_cfg;     // clamped lane count from the config port
    logic [LEN_W:0]   len_eff;     // lane count governing this cycle
    logic [LEN_W-1:0] cnt_q, cnt_nxt;
    logic             ready_en_q;
    logic             accept;
    logic [0:ARRAY_MAX_L-1]                  lane_en;
    logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  row_q;
    logic [0:ARRAY_MAX_L-1]                  row_valid_q;

    // The first row of a batch uses the live config; later rows use the latch.
    assign len_cfg  = (LEN_W+1)'(clamp_len(32'(cfg_len_m1), ARRAY_MAX_L));
    assign len_eff  = (state == IDLE) ? len_cfg : len_q;
    assign in_ready = ready_en_q && ((state == IDLE) || (state == STREAM));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == STREAM) || (state == FLUSH);
    assign done     = (state == DONE);

    // Next-state and flush counter: flush covers the L-1 cycles the last
    // row's upper lanes still need to emerge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (len_eff == (LEN_W+1)'(1)) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = FLUSH;
                            cnt_nxt   = LEN_W'(len_eff - 1'b1);
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            FLUSH: begin
                cnt_nxt = cnt_q - 1'b1;
                if (cnt_q <= LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Active lanes of an accepted row; everything else enters as a bubble.
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < ARRAY_MAX_L; k++) begin
            lane_en[k] = accept && (k < int'(len_eff));
        end
    end

    // State, counter, batch length latch and post-reset ready enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_q      <= cnt_nxt;
            ready_en_q <= 1'b1;
            if ((state == IDLE) && accept) begin
                len_q <= len_cfg;
            end
        end
    end

    // Common input register feeding every lane's delay chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q       <= '0;
            row_valid_q <= '0;
        end else begin
            row_valid_q <= lane_en;
            for (int k = 0; k < ARRAY_MAX_L; k++) begin
                row_q[k] <= lane_en[k] ? in_row[k] : '0;
            end
        end
    end

    for (genvar k = 0; k < ARRAY_MAX_L; k++) begin : g_lane
        sys_array_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (k)
        ) u_delay (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_data   (row_q[k]),
            .in_valid  (row_valid_q[k]),
            .out_data  (out_data[k]),
            .out_valid (out_lane_valid[k])
        );
    end

endmodule

// File: tb/tb_sys_array_input_skew.sv
// Bench for sys_array_input_skew: per-lane expected queues stamped with the
// cycle each element must appear, checked every cycle on the falling edge.
module tb_sys_array_input_skew;

    localparam int DW = 8;
    localparam int NL = 10;
    localparam int LW = 4;

    typedef logic [0:NL-1][DW-1:0] row_t;

    logic          clk;
    logic          reset_n;
    logic [LW-1:0] cfg_len_m1;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    row_t          in_row;
    row_t          out_data;
    logic [0:NL-1] out_lane_valid;
    logic          busy;
    logic          done;

    sys_array_input_skew #(
        .DATA_WIDTH  (DW),
        .ARRAY_MAX_L (NL),
        .LEN_W       (LW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_len_m1     (cfg_len_m1),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_row         (in_row),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .busy           (busy),
        .done           (done)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [39:0] exp_q [NL][$];   // {due cycle, data}
    int   done_due  = -1;
    int   batch_len = 2;
    logic in_batch  = 1'b0;
    int   n_vec     = 0;
    int   n_err     = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int k = 0; k < NL; k++) r[k] = DW'($urandom_range(0, 255));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input row_t row, input logic last);
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        @(negedge clk);
        check("in_ready", 128'(in_ready), 128'(1'b1));
        check("busy_in", 128'(busy), 128'(in_batch));
        for (int k = 0; k < batch_len; k++)
            exp_q[k].push_back({32'(cyc + 1 + k), row[k]});
        if (last) begin
            done_due = cyc + batch_len;
            in_batch = 1'b0;
        end else begin
            in_batch = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_row   = rand_row();
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_row   = rand_row();
        @(negedge clk);
        check("bubble_ready", 128'(in_ready), 128'(1'b1));
        check("bubble_busy", 128'(busy), 128'(1'b1));
        tick();
    endtask

    // Cycles after the last row: L-1 flush cycles plus the done cycle.
    task automatic check_tail(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("tail_ready", 128'(in_ready), 128'(1'b0));
            check("tail_busy", 128'(busy), 128'(i < len - 1));
            tick();
        end
        @(negedge clk);
        check("idle_ready", 128'(in_ready), 128'(1'b1));
        check("idle_busy", 128'(busy), 128'(1'b0));
        tick();
    endtask

    task automatic batch_l2();
        row_t r;
        cfg_len_m1 = LW'(1);
        batch_len  = 2;
        for (int i = 0; i < 5; i++) begin
            r    = rand_row();
            r[0] = DW'(2 * i + 1);
            r[1] = DW'(2 * i + 2);
            drive_row(r, i == 4);
        end
        check_tail(2);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        row_t          ed;
        logic [0:NL-1] ev;
        logic [39:0]   e;
        ed = '0;
        ev = '0;
        for (int k = 0; k < NL; k++) begin
            if (exp_q[k].size() > 0 && exp_q[k][0][39:8] == 32'(cyc)) begin
                e     = exp_q[k].pop_front();
                ed[k] = e[7:0];
                ev[k] = 1'b1;
            end
        end
        check("out_data", 128'(out_data), 128'(ed));
        check("lane_valid", 128'(out_lane_valid), 128'(ev));
        check("done", 128'(done), 128'(cyc == done_due));
    end

    // ---------------- main sequence ----------------
    initial begin
        row_t r;
        int   left;
        reset_n    = 1'b0;
        cfg_len_m1 = LW'(1);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_row     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 128'(in_ready), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        tick();
        reset_n = 1'b1;
        tick();

        // L=2, five back-to-back rows.
        batch_l2();
        repeat (2) tick();

        // L=4, two rows; flush 3 cycles, ready low 4.
        cfg_len_m1 = LW'(3);
        batch_len  = 4;
        for (int i = 0; i < 2; i++) begin
            r = rand_row();
            for (int k = 0; k < 4; k++) r[k] = DW'(4 * i + k + 1);
            drive_row(r, i == 1);
        end
        check_tail(4);

        // L=3 with a bubble between rows 2 and 3.
        cfg_len_m1 = LW'(2);
        batch_len  = 3;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bubble();
            r = rand_row();
            for (int k = 0; k < 3; k++) r[k] = DW'(3 * i + k + 1);
            drive_row(r, i == 2);
        end
        check_tail(3);

        // L=1, single row with last straight from IDLE.
        cfg_len_m1 = LW'(0);
        batch_len  = 1;
        drive_row(rand_row(), 1'b1);
        check_tail(1);
        tick();

        // Reset during FLUSH: everything discarded, no done.
        cfg_len_m1 = LW'(3);
        batch_len  = 4;
        drive_row(rand_row(), 1'b0);
        drive_row(rand_row(), 1'b1);
        reset_n = 1'b0;
        for (int k = 0; k < NL; k++) exp_q[k].delete();
        done_due = -1;
        in_batch = 1'b0;
        #1;
        check("rst_mid_data", 128'(out_data), 128'(0));
        check("rst_mid_valid", 128'(out_lane_valid), 128'(0));
        check("rst_mid_ready", 128'(in_ready), 128'(1'b0));
        check("rst_mid_busy", 128'(busy), 128'(1'b0));
        check("rst_mid_done", 128'(done), 128'(1'b0));
        repeat (4) tick();
        reset_n = 1'b1;
        tick();
        batch_l2();

        // Over-range length clamps to all lanes; mid-batch change ignored.
        cfg_len_m1 = LW'(15);
        batch_len  = NL;
        drive_row(rand_row(), 1'b0);
        cfg_len_m1 = LW'(0);
        drive_row(rand_row(), 1'b0);
        drive_row(rand_row(), 1'b1);
        check_tail(NL);

        repeat (3) tick();
        left = 0;
        for (int k = 0; k < NL; k++) left += exp_q[k].size();
        check("sb_drain", 128'(left), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
